up_wishbone_classic_master: RTL

- Wishbone classic initiator driven by the team's uP register request interface (up_rreq/up_rack, up_wreq/up_wack).
- It is the opposite end of the existing up_wishbone_classic responder.
- Lets internal uP-side logic (DMA setup, bridge, test sequencer) issue single read/write transfers onto a Wishbone classic bus.
- Performs one transfer at a time, returns data or an error flag, and optionally enforces a bus timeout.

---
 rtl/up_wishbone_classic_master_pkg.sv | 24 ++
 rtl/up_wishbone_classic_master_if.sv | 33 +++
 rtl/up_wishbone_classic_master_timeout.sv | 48 ++++
 rtl/up_wishbone_classic_master.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/up_wishbone_classic_master_pkg.sv
// up_wishbone_classic_master_pkg
//   Shared definitions for the uP-to-Wishbone classic master and its
//   responder-side counterpart.
//   - wb_state_e        : master FSM state encoding
//   - WB_CTI_CLASSIC    : cycle type for single classic transfers
//   - WB_BTE_LINEAR     : burst type (unused by classic, driven to zero)
//   - counter_width()   : bit width needed to count 0 .. n-1 (min 1)
package up_wishbone_classic_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  function automatic int unsigned counter_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/up_wishbone_classic_master_if.sv
// up_wishbone_classic_master_if
//   Wishbone classic bus bundle between one master and one slave.
//   Master drives : cyc, stb, we, addr, data_o, sel, cti, bte
//   Slave drives  : ack, data_i, err
//   Parameters    : ADDRESS_WIDTH (byte address bits), BUS_WIDTH (bytes)
interface up_wishbone_classic_master_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH     = 4
);

  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [BUS_WIDTH*8-1:0]   data_o;
  logic [BUS_WIDTH-1:0]     sel;
  logic [2:0]               cti;
  logic [1:0]               bte;
  logic                     ack;
  logic [BUS_WIDTH*8-1:0]   data_i;
  logic                     err;

  modport master (
    output cyc, stb, we, addr, data_o, sel, cti, bte,
    input  ack, data_i, err
  );

  modport slave (
    input  cyc, stb, we, addr, data_o, sel, cti, bte,
    output ack, data_i, err
  );

endinterface

// File: rtl/up_wishbone_classic_master_timeout.sv
// up_wb_timeout
//   Response watchdog for one Wishbone transfer. Counts cycles while a
//   transfer is outstanding and flags expiry on the cycle the count
//   reaches TIMEOUT_CYCLES-1 without a response.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     run      : a transfer is outstanding (FSM in WRITE or READ)
//     hit      : slave responded this cycle (ack or err)
//     expired  : terminate the transfer as an error this cycle
module up_wb_timeout
  import up_wishbone_classic_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hit,
  output logic expired
);

  localparam int unsigned   CW   = counter_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Idle cycles hold the count at zero, so every transfer starts from zero.
  always_comb begin
    count_d = count_q;
    if (!run || hit) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && !hit && (count_q == LAST);

endmodule

// File: rtl/up_wishbone_classic_master.sv
// up_wishbone_classic_master
//   Issues single Wishbone classic read/write transfers on behalf of the
//   uP register request interface. One transfer at a time; requests are
//   only sampled in IDLE, a simultaneous read is dropped in favour of the
//   write.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     up_wreq/up_waddr/up_wdata     : write request pulse, address, data
//     up_wack/up_werr               : write completion pulse, error flag
//     up_rreq/up_raddr              : read request pulse, address
//     up_rack/up_rdata/up_rerr      : read completion pulse, data, error flag
//     m_wb (master modport)         : Wishbone classic bus
//   Build option:
//     UP_WISHBONE_CLASSIC_MASTER_TIMEOUT_EN - when defined, a transfer with
//     no ack/err for TIMEOUT_CYCLES cycles terminates as an error.
//
//   state | meaning
//   IDLE  | no transfer; sampling up_wreq/up_rreq
//   WRITE | write cycle on the bus, waiting for ack/err
//   READ  | read cycle on the bus, waiting for ack/err
//   DONE  | completion pulse on up_wack or up_rack
module up_wishbone_classic_master
  import up_wishbone_classic_master_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  output logic                     up_rerr,

  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     up_werr,

  up_wishbone_classic_master_if.master m_wb
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  wb_state_e                state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [BUS_WIDTH-1:0]     sel_q, sel_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH*8-1:0]   wdata_q, wdata_d;
  logic [BUS_WIDTH*8-1:0]   rdata_q, rdata_d;
  logic                     rack_q, rack_d;
  logic                     wack_q, wack_d;
  logic                     rerr_q, rerr_d;
  logic                     werr_q, werr_d;

  logic busy;
  logic timeout_expired;
  logic bus_fail;
  logic bus_done;

  assign busy = (state_q == ST_WRITE) || (state_q == ST_READ);

`ifdef UP_WISHBONE_CLASSIC_MASTER_TIMEOUT_EN
  up_wb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .hit     (m_wb.ack || m_wb.err),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // err wins over ack when both arrive; a timeout behaves like err.
  assign bus_fail = m_wb.err || timeout_expired;
  assign bus_done = m_wb.ack || bus_fail;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rack_d  = 1'b0;
    wack_d  = 1'b0;
    rerr_d  = 1'b0;
    werr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (up_wreq) begin
          addr_d  = up_waddr;
          wdata_d = up_wdata;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = '1;
          state_d = ST_WRITE;
        end else if (up_rreq) begin
          addr_d  = up_raddr;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = '1;
          state_d = ST_READ;
        end
      end

      ST_WRITE, ST_READ: begin
        if (bus_done) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          state_d = ST_DONE;
          // Completion flags are registered here so they are high for
          // exactly the one cycle spent in DONE.
          if (state_q == ST_WRITE) begin
            wack_d = 1'b1;
            werr_d = bus_fail;
          end else begin
            rack_d = 1'b1;
            rerr_d = bus_fail;
            if (!bus_fail) begin
              rdata_d = m_wb.data_i;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      rerr_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      rerr_q  <= rerr_d;
      werr_q  <= werr_d;
    end
  end

  // Classic single transfers: stb always follows cyc.
  assign m_wb.cyc    = cyc_q;
  assign m_wb.stb    = cyc_q;
  assign m_wb.we     = we_q;
  assign m_wb.addr   = addr_q;
  assign m_wb.data_o = wdata_q;
  assign m_wb.sel    = sel_q;
  assign m_wb.cti    = WB_CTI_CLASSIC;
  assign m_wb.bte    = WB_BTE_LINEAR;

  assign up_rack  = rack_q;
  assign up_rdata = rdata_q;
  assign up_rerr  = rerr_q;
  assign up_wack  = wack_q;
  assign up_werr  = werr_q;

endmodule
